lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: takes one RV32I MEM-stage access, checks
// width/alignment, drives a byte-lane SRAM for one cycle and returns a response.
//
// state | meaning
// IDLE  | ready for a request; req_ready high
// WRITE | single-cycle store, byte strobes driven to the SRAM
// READ  | single-cycle load, SRAM data captured and extended
// RESP  | response held until rsp_ready
module lsu_mem_master #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;

  state_t              state, state_nxt;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic [1:0]          err_q;

  logic                accept;
  logic [1:0]          req_err;
  logic                req_illegal;
  logic                req_misaligned;
  logic [3:0]          strobe;
  logic [31:0]         load_ext;

  assign accept = req_valid && req_ready;

  // Classification works on the incoming request so an error can respond
  // one cycle after acceptance.
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_we) begin
      req_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                      req_funct3 == 3'b010);
    end else begin
      req_illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                     req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    if (req_illegal) begin
      req_err = ERR_ILL;
    end else if (req_misaligned) begin
      req_err = ERR_ALIGN;
    end else begin
      req_err = ERR_OK;
    end
  end

  always_comb begin
    strobe = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   strobe = 4'b0001;
      2'b01:   strobe = 4'b0011;
      2'b10:   strobe = 4'b1111;
      default: strobe = 4'b0000;
    endcase
  end

  always_comb begin
    load_ext = 32'h0;
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      3'b001:  load_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  load_ext = mem_read_data;
      3'b100:  load_ext = {24'h0, mem_read_data[7:0]};
      3'b101:  load_ext = {16'h0, mem_read_data[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err != ERR_OK) begin
            state_nxt = RESP;
          end else if (req_we) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      WRITE: state_nxt = RESP;
      READ:  state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= ERR_OK;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'h0;
      err_q    <= req_err;
    end else if (state == READ) begin
      rdata_q  <= load_ext;
    end
  end

  // Strobes are gated by reset combinationally so a reset in WRITE never
  // reaches the SRAM.
  assign mem_w_en       = (state == WRITE && !rst) ? strobe : 4'b0000;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a byte-wide SRAM model and
// hand-computed expected responses.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [3:0]  mem_w_en;
  logic [15:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [7:0]  mem [0:65535];
  int          wcnt;
  int          checks;
  int          errors;

  lsu_mem_master #(.ADDR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_w_en       (mem_w_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = {mem[16'(mem_address + 16'd3)], mem[16'(mem_address + 16'd2)],
                          mem[16'(mem_address + 16'd1)], mem[mem_address]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_w_en[k]) mem[16'(mem_address + 16'(k))] <= mem_write_data[8*k +: 8];
    end
    if (mem_w_en != 4'b0000) wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request with rsp_ready high; returns response, latency in
  // cycles after acceptance, and strobe/address seen in the first cycle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [15:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] er, output int lat,
                        output logic [3:0] wen1, output logic [15:0] addr1);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 16'hAAAA; req_wdata = 32'h5555AAAA;
    lat = 0; wen1 = 4'b0; addr1 = 16'h0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        wen1 = mem_w_en;
        addr1 = mem_address;
      end
    end while (!rsp_valid && lat < 20);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic [1:0]  er;
  int          lat;
  logic [3:0]  wen1;
  logic [15:0] addr1;
  int          w0;

  initial begin
    checks = 0; errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
    @(posedge clk); #1;

    // store word, then read it back
    w0 = wcnt;
    do_req(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, rd, er, lat, wen1, addr1);
    check("sw_wen", 32'(wen1), 32'hF);
    check("sw_addr", 32'(addr1), 32'h0010);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'h0);
    check("sw_wcycles", 32'(wcnt - w0), 32'd1);
    do_req(1'b0, 3'b010, 16'h0010, 32'h0, rd, er, lat, wen1, addr1);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_wen", 32'(wen1), 32'd0);

    // load extension
    mem[16'h20] = 8'hF0; mem[16'h21] = 8'h80; mem[16'h22] = 8'h00; mem[16'h23] = 8'h00;
    do_req(1'b0, 3'b000, 16'h0020, 32'h0, rd, er, lat, wen1, addr1);
    check("lb", rd, 32'hFFFFFFF0);
    do_req(1'b0, 3'b100, 16'h0020, 32'h0, rd, er, lat, wen1, addr1);
    check("lbu", rd, 32'h000000F0);
    do_req(1'b0, 3'b001, 16'h0020, 32'h0, rd, er, lat, wen1, addr1);
    check("lh", rd, 32'hFFFF80F0);
    do_req(1'b0, 3'b101, 16'h0020, 32'h0, rd, er, lat, wen1, addr1);
    check("lhu", rd, 32'h000080F0);
    check("lhu_err", 32'(er), 32'd0);

    // misaligned and illegal requests: respond after one cycle, no writes
    w0 = wcnt;
    do_req(1'b1, 3'b001, 16'h0031, 32'h12345678, rd, er, lat, wen1, addr1);
    check("sh_mis_err", 32'(er), 32'd1);
    check("sh_mis_rdata", rd, 32'h0);
    check("sh_mis_lat", 32'(lat), 32'd1);
    do_req(1'b0, 3'b010, 16'h0042, 32'h0, rd, er, lat, wen1, addr1);
    check("lw_mis_err", 32'(er), 32'd1);
    do_req(1'b0, 3'b011, 16'h0040, 32'h0, rd, er, lat, wen1, addr1);
    check("ld_ill_err", 32'(er), 32'd2);
    check("ld_ill_lat", 32'(lat), 32'd1);
    do_req(1'b1, 3'b100, 16'h0040, 32'hCAFEF00D, rd, er, lat, wen1, addr1);
    check("st_ill_err", 32'(er), 32'd2);
    do_req(1'b1, 3'b101, 16'h0031, 32'hCAFEF00D, rd, er, lat, wen1, addr1);
    check("ill_over_mis", 32'(er), 32'd2);
    check("err_no_write", 32'(wcnt - w0), 32'd0);
    check("err_mem_40", 32'(mem[16'h40]), 32'h0);

    // byte and halfword stores, then wrapping word store
    do_req(1'b1, 3'b000, 16'h0060, 32'hAABBCCDD, rd, er, lat, wen1, addr1);
    check("sb_wen", 32'(wen1), 32'h1);
    do_req(1'b1, 3'b001, 16'h0062, 32'h11223344, rd, er, lat, wen1, addr1);
    check("sh_wen", 32'(wen1), 32'h3);
    do_req(1'b0, 3'b010, 16'h0060, 32'h0, rd, er, lat, wen1, addr1);
    check("sb_sh_readback", rd, 32'h334400DD);
    do_req(1'b1, 3'b010, 16'hFFFC, 32'h11223344, rd, er, lat, wen1, addr1);
    check("wrap_lo", 32'(mem[16'hFFFC]), 32'h44);
    check("wrap_hi", 32'(mem[16'hFFFF]), 32'h11);
    check("wrap_no_spill", 32'(mem[16'h0000]), 32'h0);

    // backpressure: response held while rsp_ready low
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;

    // reset during WRITE of sb 0x0050
    mem[16'h50] = 8'h3C;
    w0 = wcnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 16'h0050; req_wdata = 32'h000000A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstw_wen", 32'(mem_w_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_mem", 32'(mem[16'h50]), 32'h3C);
    check("rstw_wcycles", 32'(wcnt - w0), 32'd0);
    check("rstw_req_ready", 32'(req_ready), 32'd1);
    check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstw_rsp_err", 32'(rsp_err), 32'd0);
    check("rstw_mem_address", 32'(mem_address), 32'd0);
    check("rstw_mem_write_data", mem_write_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial wcnt = 0;

endmodule
